// File: rtl/servio_dpram.sv
// ============================================================================
//  Module      : servio_dpram
//  Description : Simple dual-port RAM with two Avalon-MM slave ports
//                (s0 read-only, s1 write-only). Supports byte enables,
//                1- or 2-cycle read latency, selectable read-during-write
//                result and a post-reset clear sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module servio_dpram #(
    parameter int                    DATA_DEPTH     = 1024,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    RDW_MODE       = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    localparam int                   AW             = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
    localparam int                   BW             = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // s0: read port
    input  logic [AW-1:0]         avs_s0_address,
    input  logic                  avs_s0_read,
    output logic                  avs_s0_waitrequest,
    output logic [DATA_WIDTH-1:0] avs_s0_readdata,
    output logic                  avs_s0_readdatavalid,
    // s1: write port
    input  logic [AW-1:0]         avs_s1_address,
    input  logic                  avs_s1_write,
    input  logic [DATA_WIDTH-1:0] avs_s1_writedata,
    input  logic [BW-1:0]         avs_s1_byteenable,
    output logic                  avs_s1_waitrequest,
    // status
    output logic                  clear_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]  ST_CLEAR = 1'b0;
    localparam logic [0:0]  ST_READY = 1'b1;
    localparam logic [AW:0] C_DEPTH  = (AW+1)'(DATA_DEPTH);

    // ------------------------------------------------------------------------
    // Parameter sanity checks (elaboration time)
    // ------------------------------------------------------------------------
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("servio_dpram: READ_LATENCY must be 1 or 2");
    end

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("servio_dpram: DATA_WIDTH must be a multiple of 8");
    end

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [0:DATA_DEPTH-1];

    logic [0:0]            r_state;
    logic [AW:0]           r_clr_cnt;
    logic [AW:0]           w_clr_next;
    logic [AW-1:0]         w_clr_addr;
    logic                  w_busy;
    logic                  w_clr_en;

    logic                  w_rd_accept;
    logic                  w_wr_accept;
    logic                  w_rd_in_range;
    logic                  w_wr_in_range;
    logic                  w_wr_en;
    logic                  w_rdw_hit;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_next;

    logic                  r_rd_vld1;
    logic [DATA_WIDTH-1:0] r_rd_data1;

    // ------------------------------------------------------------------------
    // Handshake and address qualification
    // ------------------------------------------------------------------------
    assign w_busy        = (r_state == ST_CLEAR);
    assign w_rd_accept   = avs_s0_read  & ~w_busy;
    assign w_wr_accept   = avs_s1_write & ~w_busy;
    // Addresses past the last word only exist when the depth is not a power of two
    assign w_rd_in_range = ({1'b0, avs_s0_address} < C_DEPTH);
    assign w_wr_in_range = ({1'b0, avs_s1_address} < C_DEPTH);
    assign w_wr_en       = w_wr_accept & w_wr_in_range;
    // A clear step is suppressed on a reset cycle so the walk restarts cleanly at 0
    assign w_clr_en      = w_busy & ~reset;
    assign w_clr_addr    = r_clr_cnt[AW-1:0];
    assign w_clr_next    = r_clr_cnt + 1'b1;

    assign avs_s0_waitrequest = w_busy;
    assign avs_s1_waitrequest = w_busy;
    assign clear_busy         = w_busy;

    // ------------------------------------------------------------------------
    // Clear / ready state machine with word counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= w_clr_next;
            if (w_clr_next == C_DEPTH) begin
                r_state <= ST_READY;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage array: clear sequencer has the port while busy, else byte writes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_mem[w_clr_addr] <= CLEAR_VALUE;
        end else if (w_wr_en) begin
            for (int i = 0; i < BW; i++) begin
                if (avs_s1_byteenable[i]) begin
                    r_mem[avs_s1_address][8*i +: 8] <= avs_s1_writedata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read data selection: array word, byte-merged bypass, or zero
    // ------------------------------------------------------------------------
    assign w_rd_word = r_mem[avs_s0_address];
    assign w_rdw_hit = w_wr_en & w_rd_accept & (avs_s0_address == avs_s1_address);

    // Stored word with the write's enabled lanes substituted
    always_comb begin
        w_merged = w_rd_word;
        for (int i = 0; i < BW; i++) begin
            if (avs_s1_byteenable[i]) begin
                w_merged[8*i +: 8] = avs_s1_writedata[8*i +: 8];
            end
        end
    end

    // Out-of-range reads return zero; same-address collisions optionally bypass
    always_comb begin
        w_rd_next = '0;
        if (w_rd_in_range) begin
            if ((RDW_MODE != 0) && w_rdw_hit) begin
                w_rd_next = w_merged;
            end else begin
                w_rd_next = w_rd_word;
            end
        end
    end

    // ------------------------------------------------------------------------
    // First read stage: data register only loads on an accepted read
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld1  <= 1'b0;
            r_rd_data1 <= '0;
        end else begin
            r_rd_vld1 <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data1 <= w_rd_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional output register for two-cycle latency
    // ------------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_rd_vld2;
        logic [DATA_WIDTH-1:0] r_rd_data2;

        // Second stage holds its value until a new result arrives
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd_vld2  <= 1'b0;
                r_rd_data2 <= '0;
            end else begin
                r_rd_vld2 <= r_rd_vld1;
                if (r_rd_vld1) begin
                    r_rd_data2 <= r_rd_data1;
                end
            end
        end

        assign avs_s0_readdatavalid = r_rd_vld2;
        assign avs_s0_readdata      = r_rd_data2;
    end else begin : g_lat1
        assign avs_s0_readdatavalid = r_rd_vld1;
        assign avs_s0_readdata      = r_rd_data1;
    end

endmodule

`default_nettype wire

// File: tb/tb_servio_dpram.sv
// ============================================================================
//  Module      : tb_servio_dpram
//  Description : Self-checking bench for servio_dpram. Two instances share
//                the same stimulus: A = latency 2 / old-data RDW,
//                B = latency 1 / new-data RDW, both 12 words deep.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_servio_dpram;

    localparam int          DEPTH = 12;
    localparam int          AW    = 4;
    localparam logic [31:0] CV    = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [AW-1:0] raddr = '0;
    logic [AW-1:0] waddr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    logic        a_rwait, a_wwait, a_rvalid, a_busy;
    logic [31:0] a_rdata;
    logic        b_rwait, b_wwait, b_rvalid, b_busy;
    logic [31:0] b_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    typedef struct {
        logic        rd;
        logic [3:0]  raddr;
        logic        wr;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t tbl [17];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    servio_dpram #(
        .DATA_DEPTH     (DEPTH),
        .DATA_WIDTH     (32),
        .READ_LATENCY   (2),
        .RDW_MODE       (0),
        .CLEAR_ON_RESET (1),
        .CLEAR_VALUE    (CV)
    ) u_dut_a (
        .clk                  (clk),
        .reset                (reset),
        .avs_s0_address       (raddr),
        .avs_s0_read          (rd),
        .avs_s0_waitrequest   (a_rwait),
        .avs_s0_readdata      (a_rdata),
        .avs_s0_readdatavalid (a_rvalid),
        .avs_s1_address       (waddr),
        .avs_s1_write         (wr),
        .avs_s1_writedata     (wdata),
        .avs_s1_byteenable    (be),
        .avs_s1_waitrequest   (a_wwait),
        .clear_busy           (a_busy)
    );

    servio_dpram #(
        .DATA_DEPTH     (DEPTH),
        .DATA_WIDTH     (32),
        .READ_LATENCY   (1),
        .RDW_MODE       (1),
        .CLEAR_ON_RESET (1),
        .CLEAR_VALUE    (CV)
    ) u_dut_b (
        .clk                  (clk),
        .reset                (reset),
        .avs_s0_address       (raddr),
        .avs_s0_read          (rd),
        .avs_s0_waitrequest   (b_rwait),
        .avs_s0_readdata      (b_rdata),
        .avs_s0_readdatavalid (b_rvalid),
        .avs_s1_address       (waddr),
        .avs_s1_write         (wr),
        .avs_s1_writedata     (wdata),
        .avs_s1_byteenable    (be),
        .avs_s1_waitrequest   (b_wwait),
        .clear_busy           (b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare returned data/latency, then record newly accepted reads
    always @(negedge clk) begin
        exp_t e;
        if (a_rvalid) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
            end else begin
                e = qa.pop_front();
                chk("a_rdata", a_rdata, e.data);
                chk("a_latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
        if (b_rvalid) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
            end else begin
                e = qb.pop_front();
                chk("b_rdata", b_rdata, e.data);
                chk("b_latency", 32'(cyc - e.cyc), 32'd1);
            end
        end
        if (reset) begin
            qa.delete();
            qb.delete();
        end else begin
            if (rd && !a_rwait) qa.push_back('{data: exp_a, cyc: cyc});
            if (rd && !b_rwait) qb.push_back('{data: exp_b, cyc: cyc});
        end
    end

    // Measure how long each instance stays busy / stalls both ports
    task automatic count_clear(input string tag);
        int na = 0;
        int nb = 0;
        int nw = 0;
        for (int i = 0; i < 100; i++) begin
            if (!a_busy && !b_busy) break;
            if (a_busy) na++;
            if (b_busy) nb++;
            if (a_rwait && a_wwait && b_rwait && b_wwait) nw++;
            tick();
        end
        chk({tag, "_busy_cycles_a"}, 32'(na), 32'd12);
        chk({tag, "_busy_cycles_b"}, 32'(nb), 32'd12);
        chk({tag, "_wait_cycles"}, 32'(nw), 32'd12);
        chk({tag, "_ready_waits"}, {28'd0, a_rwait, a_wwait, b_rwait, b_wwait}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            tick();
        end
    endtask

    // Read every word (expect the clear value) plus one out-of-range address
    task automatic read_all();
        wr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd    = 1'b1;
            raddr = AW'(i);
            exp_a = CV;
            exp_b = CV;
            tick();
        end
        raddr = 4'd13;
        exp_a = 32'h0;
        exp_b = 32'h0;
        tick();
        rd = 1'b0;
        drain();
    endtask

    initial begin
        //            rd    ra     wr    wa     wdata          be     exp A          exp B
        tbl[0]  = '{1'b0, 4'd0,  1'b1, 4'd3,  32'h11223344, 4'hF, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 4'd0,  1'b1, 4'd3,  32'hFFFFFFFF, 4'h5, 32'h0,         32'h0};
        tbl[2]  = '{1'b1, 4'd3,  1'b0, 4'd0,  32'h0,        4'h0, 32'h11FF33FF,  32'h11FF33FF};
        tbl[3]  = '{1'b0, 4'd0,  1'b1, 4'd5,  32'h0,        4'hF, 32'h0,         32'h0};
        tbl[4]  = '{1'b1, 4'd5,  1'b1, 4'd5,  32'hDEADBEEF, 4'h3, 32'h0,         32'h0000BEEF};
        tbl[5]  = '{1'b1, 4'd5,  1'b0, 4'd0,  32'h0,        4'h0, 32'h0000BEEF,  32'h0000BEEF};
        tbl[6]  = '{1'b1, 4'd1,  1'b1, 4'd13, 32'h12345678, 4'hF, CV,            CV};
        tbl[7]  = '{1'b1, 4'd13, 1'b0, 4'd0,  32'h0,        4'h0, 32'h0,         32'h0};
        tbl[8]  = '{1'b1, 4'd1,  1'b0, 4'd0,  32'h0,        4'h0, CV,            CV};
        tbl[9]  = '{1'b1, 4'd2,  1'b1, 4'd1,  32'hCAFEF00D, 4'h0, CV,            CV};
        tbl[10] = '{1'b1, 4'd1,  1'b1, 4'd2,  32'h01020304, 4'hF, CV,            CV};
        tbl[11] = '{1'b1, 4'd2,  1'b0, 4'd0,  32'h0,        4'h0, 32'h01020304,  32'h01020304};
        tbl[12] = '{1'b1, 4'd11, 1'b1, 4'd11, 32'h55555555, 4'h8, CV,            32'h55A5A5A5};
        tbl[13] = '{1'b1, 4'd11, 1'b0, 4'd0,  32'h0,        4'h0, 32'h55A5A5A5,  32'h55A5A5A5};
        tbl[14] = '{1'b1, 4'd1,  1'b0, 4'd0,  32'h0,        4'h0, CV,            CV};
        tbl[15] = '{1'b1, 4'd2,  1'b0, 4'd0,  32'h0,        4'h0, 32'h01020304,  32'h01020304};
        tbl[16] = '{1'b1, 4'd3,  1'b0, 4'd0,  32'h0,        4'h0, 32'h11FF33FF,  32'h11FF33FF};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_a_valid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_valid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        chk("rst_busy_waits", {27'd0, a_busy, a_rwait, a_wwait, b_rwait, b_wwait}, 32'h1F);

        // Clear sequence; requests presented meanwhile must be ignored
        reset = 1'b0;
        rd    = 1'b1;
        raddr = 4'd0;
        wr    = 1'b1;
        waddr = 4'd0;
        wdata = 32'h0;
        be    = 4'hF;
        count_clear("init");
        rd = 1'b0;
        wr = 1'b0;
        read_all();

        // Table-driven vectors, one per cycle
        for (int i = 0; i < 17; i++) begin
            rd    = tbl[i].rd;
            raddr = tbl[i].raddr;
            wr    = tbl[i].wr;
            waddr = tbl[i].waddr;
            wdata = tbl[i].wdata;
            be    = tbl[i].be;
            exp_a = tbl[i].ea;
            exp_b = tbl[i].eb;
            tick();
        end
        rd = 1'b0;
        wr = 1'b0;
        drain();
        repeat (2) tick();
        chk("a_rdata_hold", a_rdata, 32'h11FF33FF);
        chk("b_rdata_hold", b_rdata, 32'h11FF33FF);

        // Reset with a read in flight: no valid may follow for dropped reads
        rd    = 1'b1;
        raddr = 4'd1;
        exp_a = CV;
        exp_b = CV;
        tick();
        reset = 1'b1;
        raddr = 4'd2;
        tick();
        rd = 1'b0;
        repeat (2) tick();
        chk("flush_a_valid", {31'd0, a_rvalid}, 32'd0);
        chk("flush_a_rdata", a_rdata, 32'd0);
        chk("flush_b_rdata", b_rdata, 32'd0);
        chk("flush_busy", {30'd0, a_busy, b_busy}, 32'd3);
        reset = 1'b0;
        count_clear("post_flush");

        // Reset part-way through a clear restarts a full walk
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_clear("mid_clear");
        read_all();

        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb_empty", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/servio_dpram.md
Name: servio_dpram

Overview:
- Parametrised simple-dual-port RAM with two Avalon-MM slave ports: s0 read-only, s1 write-only.
- Generalises the servio byte RAM with:
  - full-width storage of arbitrary DATA_WIDTH and byte enables,
  - selectable read latency and read-during-write mode,
  - a hardware clear sequencer that initialises every word after reset.
- Sits between servio bus masters and local buffers: instruction/data staging, mailbox memory.

Parameters:
- DATA_DEPTH, 1024, number of words; need not be a power of two.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (byte-merged).
- CLEAR_ON_RESET, 1, 1 = walk and clear all words after reset; 0 = ready immediately.
- CLEAR_VALUE, 0, DATA_WIDTH-bit value written to each word during clear.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- avs_s0_address  input  aw  read word address; aw = $clog2(DATA_DEPTH).
- avs_s0_read  input  1  read request.
- avs_s0_waitrequest  output  1  high = read not accepted this cycle.
- avs_s0_readdata  output  dw  read data; dw = DATA_WIDTH.
- avs_s0_readdatavalid  output  1  readdata valid this cycle.
- avs_s1_address  input  aw  write word address.
- avs_s1_write  input  1  write request.
- avs_s1_writedata  input  dw  write data.
- avs_s1_byteenable  input  dw/8  per-byte write enable; bit i controls bits [8i+7:8i].
- avs_s1_waitrequest  output  1  high = write not accepted this cycle.
- clear_busy  output  1  high while the clear sequencer runs.

Behaviour:
- Reset values (cycle after reset high):
  - avs_s0_readdata = 0, avs_s0_readdatavalid = 0.
  - Read pipeline flushed; in-flight reads are dropped, no valid is issued for them.
  - Clear address counter = 0.
  - clear_busy = CLEAR_ON_RESET; both waitrequests = CLEAR_ON_RESET.
- State machine: two states, CLEAR and READY.
  - reset -> CLEAR if CLEAR_ON_RESET, else READY.
  - CLEAR: one word per cycle, addresses 0..DATA_DEPTH-1, each written with CLEAR_VALUE (all bytes). After writing DATA_DEPTH-1, next state is READY. Clear takes exactly DATA_DEPTH cycles.
  - Both waitrequests and clear_busy are high throughout CLEAR and low in READY. Master requests during CLEAR are not performed.
  - reset asserted during CLEAR restarts the clear at address 0.
- Read path:
  - A read is accepted on a cycle with avs_s0_read=1 and avs_s0_waitrequest=0.
  - avs_s0_readdatavalid is high exactly READ_LATENCY cycles after acceptance, for one cycle.
  - Fully pipelined: one read accepted per cycle, results returned in order.
  - READ_LATENCY=2 adds an output register after the array register.
  - readdata holds its last value when readdatavalid=0.
- Write path:
  - A write is accepted on a cycle with avs_s1_write=1 and avs_s1_waitrequest=0.
  - Only enabled byte lanes update at the rising edge. byteenable=0 is a legal no-op.
- Out-of-range addresses (address >= DATA_DEPTH, possible when depth is not a power of two):
  - Writes are dropped.
  - Reads complete with normal latency and return 0.
- Read-during-write, same address, same cycle, both accepted:
  - RDW_MODE=0: read returns pre-write contents.
  - RDW_MODE=1: read returns the stored word with enabled lanes replaced by writedata. Implemented by bypass mux, not by array behaviour.
  - The stored result is identical in both modes.
- Different addresses in the same cycle are fully independent.
- Width rules: aw = max(1, $clog2(DATA_DEPTH)). Byte-lane count = DATA_WIDTH/8. No arithmetic beyond the clear counter, which is aw+1 bits wide to detect terminal count.
- Elaboration check: an illegal READ_LATENCY, or a DATA_WIDTH that is not a multiple of 8, triggers $error under simulation.

Test Plan:
- Clear sequence (DEPTH=16, CLEAR_VALUE=32'hA5A5A5A5): deassert reset -> clear_busy and both waitrequests high for exactly 16 cycles. Then reads of addr 0..15 each return A5A5A5A5.
- Byte enables: write addr 3 = 32'h11223344 with be=4'b1111, then write 32'hFFFFFFFF with be=4'b0101 -> read addr 3 returns 32'h11FF33FF.
- Latency/pipelining (READ_LATENCY=2): back-to-back reads of addrs 1,2,3 on cycles t..t+2 -> readdatavalid high on t+2..t+4, data in order.
- Read-during-write on addr 5 (old word 0, write 32'hDEADBEEF be=4'b0011) -> RDW_MODE=0 returns 0, RDW_MODE=1 returns 32'h0000BEEF. The next read of addr 5 returns 32'h0000BEEF in both modes.
- Reset mid-operation: assert reset with 2 reads in flight and the clear at address 7 -> no readdatavalid follows. After release, the clear restarts at address 0 and runs a full DEPTH cycles.
- Non-power-of-two depth (DEPTH=12): write addr 13 = 32'h12345678 -> no array change. Read addr 13 returns 0 with normal latency.
